uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage that consumes the line driven by the team's UART transmitter and recovers each frame. It sits directly downstream of the transmitter on the same `clk`, using one bit per clock cycle. It performs three jobs:
- synchronises the line and detects the start bit;
- shifts in 5–9 data bits LSB-first, then checks the optional parity bit and the 1 or 2 stop bits;
- presents the frame and its error flags through a one-entry valid/ready holding register.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `rx`; must be ≥2.
- `clk` input 1: clock; one line bit per cycle.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: serial line; idle high.
- `parity` input 1: 1 means a parity bit follows the data.
- `parity_type` input 1: 0 = even parity, 1 = odd parity.
- `stop_bits` input 1: 0 = one stop bit, 1 = two stop bits.
- `frame_length` input 4: number of data bits, 5..9.
- `rx_data` output 9: received data, LSB = first bit; bits at and above `frame_length` read 0.
- `rx_valid` output 1: holding register holds an unconsumed frame.
- `rx_ready` input 1: consumer accepts the frame.
- `parity_err` output 1: parity mismatch for the frame in `rx_data`; valid while `rx_valid` is high.
- `frame_err` output 1: a stop bit was sampled 0 for the frame in `rx_data`; valid while `rx_valid` is high.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rx_s` is `rx` after `SYNC_STAGES` flops. The synchroniser flops reset to 1.
- Configuration (`parity`, `parity_type`, `stop_bits`, `frame_length`) is latched in the cycle the start bit is detected. Changes mid-frame are ignored.
- `frame_length` is clamped: values below 5 are treated as 5, values above 9 as 9.
- FSM states:
  - IDLE: if `rx_s` = 0, this cycle is the start bit. Latch the configuration, clear the bit counter and shift register, go to DATA.
  - DATA: store `rx_s` into bit[count] and increment count. When count = len−1, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compute the expected bit. For even parity it is the XOR of the data bits; for odd parity it is the inverse of that XOR. Set the internal parity flag if `rx_s` ≠ expected. Go to STOP1.
  - STOP1: set the internal frame flag if `rx_s` = 0. If `stop_bits` = 1, go to STOP2; else deliver the frame.
  - STOP2: set the internal frame flag if `rx_s` = 0, then deliver the frame.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line (break) from being read as new start bits.
- Deliver:
  - If the holding register is free, load data and flags and set `rx_valid`. The register counts as free when `rx_valid` = 0, or when `rx_valid` and `rx_ready` are both high in the same cycle.
  - Otherwise, keep the held frame unchanged, drop the new frame, and pulse `overrun`.
  - After delivery, go to IDLE if the frame flag is clear, else WAIT_HIGH.
- Handshake: `rx_valid` clears on a cycle where `rx_valid` and `rx_ready` are both high, unless a new frame is loaded in that same cycle. While `rx_valid` is high, `rx_data` and the flags are stable.

## Timing
- Reset values:
  - `rx_data` = 0; `rx_valid`, `parity_err`, `frame_err`, `overrun`, `busy` = 0.
  - FSM in IDLE; synchroniser flops = 1.
- Reset mid-frame aborts the frame. No frame is delivered and no flag is raised.
- Latency: `rx_valid` rises on the clock edge `SYNC_STAGES`+1 cycles after the edge that puts the last stop bit on `rx`. With the default `SYNC_STAGES` = 2 this is 3 cycles.
- Back-to-back frames: a start bit in the cycle immediately after the last stop bit is accepted. There is no mandatory idle gap.
- Frame time: 1 (start) + len + parity + stop cycles. Each line bit is sampled exactly once.
- `busy` is high from the cycle after start detection through the deliver cycle. It is also high while in WAIT_HIGH.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, DATA, PARITY, STOP1, STOP2, WAIT_HIGH);
  - `FRAME_LEN_MIN` = 5, `FRAME_LEN_MAX` = 9;
  - parity type encoding `PARITY_EVEN` = 0, `PARITY_ODD` = 1 (shared with the transmitter).
- Sub-module `uart_sync`: parameterised N-flop synchroniser with reset value 1, on asynchronous `rst`.

## Test plan
- 8N1 (`frame_length`=8, `parity`=0, `stop_bits`=0), data 0xA5, `rx_ready`=1: `rx_data`=0x0A5 with `rx_valid` high 3 cycles after the stop bit; `parity_err`=`frame_err`=0.
- 9E1, data 0x1C3 with parity bit 1: `rx_data`=0x1C3, `parity_err`=0. Repeat with the parity bit sent as 0: `parity_err`=1.
- 5O2 (`frame_length`=5, `parity_type`=1, `stop_bits`=1), data 0x15 with parity 0: `rx_data`=0x015, no errors. Repeat with the second stop bit forced 0: `frame_err`=1.
- Break: 8N1 frame with the stop bit 0 and the line held 0 for 20 cycles, then high. Exactly one frame is delivered, with `frame_err`=1. `busy` stays high until `rx_s` returns to 1, and no second frame follows.
- Overrun: `rx_ready`=0, two back-to-back 8N1 frames 0x11 and 0x22. `rx_data` stays 0x011, and `overrun` pulses once at the second delivery. Raising `rx_ready` clears `rx_valid` on the next edge.
- Reset mid-frame: assert `rst` during DATA bit 3, then release. All outputs are 0 and nothing is delivered. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame-length limits and
// the parity-type encoding also used by the transmitter.
package uart_pkg;

  localparam int unsigned DATA_W        = 9;
  localparam int unsigned LEN_W         = 4;
  localparam int unsigned FRAME_LEN_MIN = 5;
  localparam int unsigned FRAME_LEN_MAX = 9;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP1     = 3'd3,
    ST_STOP2     = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Line configuration captured at start-bit detection
  typedef struct packed {
    logic             par_en;
    logic             par_odd;
    logic             two_stop;
    logic [LEN_W-1:0] len;
  } rx_cfg_t;

  // Payload held in the output register
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity_err;
    logic              frame_err;
  } rx_frame_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < LEN_W'(FRAME_LEN_MIN)) return LEN_W'(FRAME_LEN_MIN);
    if (len > LEN_W'(FRAME_LEN_MAX)) return LEN_W'(FRAME_LEN_MAX);
    return len;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for the serial line; flops reset to the idle level (1).
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: one line bit per clock, 5..9 data bits LSB-first,
// optional parity, 1 or 2 stop bits, one-entry valid/ready output register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity,
  input  logic       parity_type,
  input  logic       stop_bits,
  input  logic [3:0] frame_length,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  rx_state_e         state_q;
  rx_cfg_t           cfg_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_flag_q;
  logic              frm_flag_q;
  logic              busy_q;

  rx_frame_t         hold_q;
  logic              rx_valid_q;
  logic              overrun_q;

  logic last_stop_c;
  logic frm_final_c;
  logic slot_free_c;
  logic par_exp_c;

  // The final stop bit is sampled and the frame delivered in the same cycle
  assign last_stop_c = ((state_q == ST_STOP1) && !cfg_q.two_stop) || (state_q == ST_STOP2);
  assign frm_final_c = frm_flag_q | ~rx_s;
  assign slot_free_c = !rx_valid_q || rx_ready;
  assign par_exp_c   = (^shift_q) ^ (cfg_q.par_odd == PARITY_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cfg_q      <= '{par_en:   parity,
                            par_odd:  parity_type,
                            two_stop: stop_bits,
                            len:      clamp_len(frame_length)};
            cnt_q      <= '0;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          shift_q <= shift_q | (DATA_W'(rx_s) << cnt_q);
          cnt_q   <= cnt_q + LEN_W'(1);
          if (cnt_q == cfg_q.len - LEN_W'(1)) begin
            state_q <= cfg_q.par_en ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          par_flag_q <= (rx_s != par_exp_c);
          state_q    <= ST_STOP1;
        end
        ST_STOP1: begin
          frm_flag_q <= frm_final_c;
          if (cfg_q.two_stop) begin
            state_q <= ST_STOP2;
          end else begin
            state_q <= frm_final_c ? ST_WAIT_HIGH : ST_IDLE;
            busy_q  <= frm_final_c;
          end
        end
        ST_STOP2: begin
          frm_flag_q <= frm_final_c;
          state_q    <= frm_final_c ? ST_WAIT_HIGH : ST_IDLE;
          busy_q     <= frm_final_c;
        end
        // A held-low line after a bad stop bit must not look like new starts
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load when free, otherwise drop the frame and flag overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (last_stop_c && slot_free_c) begin
        hold_q     <= '{data:       shift_q,
                        parity_err: par_flag_q,
                        frame_err:  frm_final_c};
        rx_valid_q <= 1'b1;
      end else begin
        if (last_stop_c) begin
          overrun_q <= 1'b1;
        end
        if (rx_valid_q && rx_ready) begin
          rx_valid_q <= 1'b0;
        end
      end
    end
  end

  assign rx_data    = hold_q.data;
  assign parity_err = hold_q.parity_err;
  assign frame_err  = hold_q.frame_err;
  assign rx_valid   = rx_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized checks of uart_receiver against a frame-level
// reference model (expected data/flags computed from the framing rules).
module tb_uart_receiver;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int ovr_cnt     = 0;
  int n0;
  int o0;

  frm_t got[$];
  frm_t exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .parity       (parity),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .frame_length (frame_length),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  // Records every frame handed over (valid & ready) and every overrun pulse
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_perr"}, 32'(parity_err), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_last(input string tag, input logic [8:0] d, input logic pe, input logic fe);
    frm_t f;
    f = (got.size() > 0) ? got[got.size()-1] : '1;
    check({tag, "_data"}, 32'(f.d), 32'(d));
    check({tag, "_perr"}, 32'(f.pe), 32'(pe));
    check({tag, "_ferr"}, 32'(f.fe), 32'(fe));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  function automatic int clamp(input int l);
    return (l < 5) ? 5 : ((l > 9) ? 9 : l);
  endfunction

  // Expected delivered frame from the framing rules alone
  function automatic frm_t model(input int len, input bit pen, input bit podd, input bit two,
                                 input logic [8:0] d, input bit pbit, input bit s1, input bit s2);
    frm_t f;
    int   m;
    m    = (1 << clamp(len)) - 1;
    f.d  = d & 9'(m);
    f.pe = pen && (pbit != ((^f.d) ^ podd));
    f.fe = !s1 || (two && !s2);
    return f;
  endfunction

  // Drives one frame, one bit per negedge; returns right after driving the last stop bit
  task automatic send_frame(input int len, input bit pen, input bit podd, input bit two,
                            input logic [8:0] d, input bit pbit, input bit s1, input bit s2,
                            input bit scramble);
    int eff;
    eff = clamp(len);
    @(negedge clk);
    rx           = 1'b0;
    parity       = pen;
    parity_type  = podd;
    stop_bits    = two;
    frame_length = 4'(len);
    for (int i = 0; i < eff; i++) begin
      @(negedge clk);
      rx = d[i];
      if (scramble && i == 3) begin
        parity       = 1'($urandom);
        parity_type  = 1'($urandom);
        stop_bits    = 1'($urandom);
        frame_length = 4'($urandom);
      end
    end
    if (pen) begin
      @(negedge clk);
      rx = pbit;
    end
    @(negedge clk);
    rx = s1;
    if (two) begin
      @(negedge clk);
      rx = s2;
    end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; parity = 1'b0; parity_type = 1'b0;
    stop_bits = 1'b0; frame_length = 4'd8; rx_ready = 1'b1;
    tick(3);
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // 8N1 0xA5 with latency
    n0 = got.size();
    send_frame(8, 0, 0, 0, 9'h0A5, 0, 1, 1, 0);
    tick(2);
    check("8n1_valid_early", 32'(rx_valid), 32'd0);
    tick(1);
    check("8n1_valid", 32'(rx_valid), 32'd1);
    check("8n1_data", 32'(rx_data), 32'h0A5);
    check("8n1_perr", 32'(parity_err), 32'd0);
    check("8n1_ferr", 32'(frame_err), 32'd0);
    idle(4);
    check("8n1_count", 32'(got.size() - n0), 32'd1);

    // 9E1 good and bad parity
    send_frame(9, 1, 0, 0, 9'h1C3, 1, 1, 1, 0);
    idle(6);
    check_last("9e1_ok", 9'h1C3, 1'b0, 1'b0);
    send_frame(9, 1, 0, 0, 9'h1C3, 0, 1, 1, 0);
    idle(6);
    check_last("9e1_bad", 9'h1C3, 1'b1, 1'b0);

    // 5O2 good and second stop bit low
    send_frame(5, 1, 1, 1, 9'h015, 0, 1, 1, 0);
    idle(6);
    check_last("5o2_ok", 9'h015, 1'b0, 1'b0);
    send_frame(5, 1, 1, 1, 9'h015, 0, 1, 0, 0);
    idle(6);
    check_last("5o2_stop2", 9'h015, 1'b0, 1'b1);

    // Break: stop bit low, line held low, then released
    n0 = got.size();
    send_frame(8, 0, 0, 0, 9'h03C, 0, 0, 0, 0);
    repeat (20) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("brk_busy_low", 32'(busy), 32'd1);
    check("brk_count", 32'(got.size() - n0), 32'd1);
    check_last("brk", 9'h03C, 1'b0, 1'b1);
    @(negedge clk);
    rx = 1'b1;
    tick(2);
    check("brk_busy_wait", 32'(busy), 32'd1);
    tick(1);
    check("brk_busy_idle", 32'(busy), 32'd0);
    idle(10);
    check("brk_count_after", 32'(got.size() - n0), 32'd1);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    n0 = got.size();
    o0 = ovr_cnt;
    send_frame(8, 0, 0, 0, 9'h011, 0, 1, 1, 0);
    send_frame(8, 0, 0, 0, 9'h022, 0, 1, 1, 0);
    tick(2);
    check("ovr_before", 32'(overrun), 32'd0);
    tick(1);
    check("ovr_pulse", 32'(overrun), 32'd1);
    tick(1);
    check("ovr_after", 32'(overrun), 32'd0);
    idle(3);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h011);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_drain_valid", 32'(rx_valid), 32'd0);
    check("ovr_drain_count", 32'(got.size() - n0), 32'd1);
    check_last("ovr_drain", 9'h011, 1'b0, 1'b0);

    // Reset during data bit 3
    idle(4);
    n0 = got.size();
    parity = 1'b0; stop_bits = 1'b0; frame_length = 4'd8;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = ((8'h5A >> i) & 8'h01) != 8'h00;
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    check_quiet("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check_quiet("rst_after");
    check("rst_count", 32'(got.size() - n0), 32'd0);
    send_frame(8, 0, 0, 0, 9'h05A, 0, 1, 1, 0);
    idle(6);
    check("rst_next_count", 32'(got.size() - n0), 32'd1);
    check_last("rst_next", 9'h05A, 1'b0, 1'b0);

    // Randomized frames against the model, config scrambled mid-frame
    n0 = got.size();
    o0 = ovr_cnt;
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      int         len;
      bit         pen, podd, two, pbit, s1, s2;
      logic [8:0] d;
      frm_t       e;
      int         gap;
      len  = int'($urandom_range(0, 15));
      pen  = 1'($urandom);
      podd = 1'($urandom);
      two  = 1'($urandom);
      d    = 9'($urandom);
      e    = model(len, pen, podd, two, d, 1'b0, 1'b1, 1'b1);
      pbit = ((^e.d) ^ podd) ^ ($urandom_range(0, 5) == 0);
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      e    = model(len, pen, podd, two, d, pbit, s1, s2);
      exp_q.push_back(e);
      send_frame(len, pen, podd, two, d, pbit, s1, s2, 1'b1);
      gap = e.fe ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      idle(gap);
    end
    idle(20);
    check("rnd_count", 32'(got.size() - n0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      frm_t f;
      f = (n0 + k < got.size()) ? got[n0 + k] : '1;
      check($sformatf("rnd%0d_frame", k), 32'(f), 32'(exp_q[k]));
    end
    check("rnd_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("rnd_busy_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
